// File: rtl/modular_inverse_seq.sv
// modular_inverse_seq: sequential modular inverse (inv = a^-1 mod n) by
// iterative extended Euclid, one quotient step per clock, start/done handshake.
// Optional: define MODINV_GCD_OUT_EN to add the gcd_out result port.
module modular_inverse_seq #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned COEFF_WIDTH = WORD_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] n,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] inv,
    output logic                  error
`ifdef MODINV_GCD_OUT_EN
    ,
    output logic [WORD_WIDTH-1:0] gcd_out
`endif
);

    // Coefficients must hold +/-n plus a sign bit.
    if (COEFF_WIDTH < WORD_WIDTH + 1) begin : g_coeff_width_check
        $error("modular_inverse_seq: COEFF_WIDTH must be at least WORD_WIDTH+1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ITER   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e                        state_q;
    logic [WORD_WIDTH-1:0]         n_q;
    logic [WORD_WIDTH-1:0]         old_r_q;
    logic [WORD_WIDTH-1:0]         r_q;
    logic signed [COEFF_WIDTH-1:0] old_s_q;
    logic signed [COEFF_WIDTH-1:0] s_q;

    logic [WORD_WIDTH-1:0]         quot;
    logic signed [COEFF_WIDTH-1:0] quot_s;
    logic [WORD_WIDTH-1:0]         r_d;
    logic signed [COEFF_WIDTH-1:0] s_d;
    logic                          err_d;
    logic [WORD_WIDTH-1:0]         inv_d;

    // One Euclid step plus the final sign fix-up of the Bezout coefficient.
    always_comb begin
        quot   = '0;
        quot_s = '0;
        r_d    = '0;
        s_d    = '0;
        err_d  = 1'b0;
        inv_d  = '0;

        if (r_q != '0) begin
            quot = old_r_q / r_q;
        end
        quot_s = COEFF_WIDTH'(quot);
        r_d    = old_r_q - quot * r_q;
        s_d    = old_s_q - quot_s * s_q;

        err_d = (n_q < WORD_WIDTH'(2)) || (old_r_q != WORD_WIDTH'(1));
        // |old_s| <= n, so the negative case wraps back into [0, n-1] at WORD_WIDTH.
        if (!err_d) begin
            if (old_s_q[COEFF_WIDTH-1]) begin
                inv_d = WORD_WIDTH'(old_s_q) + n_q;
            end else begin
                inv_d = WORD_WIDTH'(old_s_q);
            end
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            old_r_q <= '0;
            r_q     <= '0;
            old_s_q <= '0;
            s_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            inv     <= '0;
            error   <= 1'b0;
`ifdef MODINV_GCD_OUT_EN
            gcd_out <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q     <= n;
                        old_r_q <= a;
                        r_q     <= n;
                        old_s_q <= COEFF_WIDTH'(1);
                        s_q     <= '0;
                        busy    <= 1'b1;
                        if (n < WORD_WIDTH'(2)) begin
                            state_q <= S_FINISH;
                        end else begin
                            state_q <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    old_r_q <= r_q;
                    r_q     <= r_d;
                    old_s_q <= s_q;
                    s_q     <= s_d;
                    if (r_d == '0) begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    inv     <= inv_d;
                    error   <= err_d;
`ifdef MODINV_GCD_OUT_EN
                    gcd_out <= (n_q < WORD_WIDTH'(2)) ? n_q : old_r_q;
`endif
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
